// File: rtl/six_bit_rotate_solver.sv
// six_bit_rotate_solver: finds the left/right rotation mapping xVal onto targetVal, one candidate per cycle.
module six_bit_rotate_solver #(
  parameter bit CANONICAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] xVal,
  input  logic [5:0] targetVal,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       direction,
  output logic [2:0] shamt
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t     state_q, state_d;
  logic [5:0] work_q, work_d, tgt_q, tgt_d;
  logic [2:0] k_q, k_d, shamt_q, shamt_d;
  logic       found_q, found_d, dir_q, dir_d;
  logic       hit, flip;
  assign hit  = work_q == tgt_q;
  // matches beyond a half turn are shorter as a right rotation
  assign flip = CANONICAL && k_q > 3'd3;
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    tgt_d   = tgt_q;
    k_d     = k_q;
    found_d = found_q;
    dir_d   = dir_q;
    shamt_d = shamt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEARCH;
        work_d  = xVal;
        tgt_d   = targetVal;
        k_d     = 3'd0;
      end
      SEARCH: if (hit || k_q == 3'd5) begin
        state_d = DONE;
        found_d = hit;
        dir_d   = !(hit && flip);
        shamt_d = !hit ? 3'd0 : flip ? 3'd6 - k_q : k_q;
      end else begin
        work_d = {work_q[4:0], work_q[5]};
        k_d    = k_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      tgt_q   <= '0;
      k_q     <= '0;
      found_q <= 1'b0;
      dir_q   <= 1'b0;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      tgt_q   <= tgt_d;
      k_q     <= k_d;
      found_q <= found_d;
      dir_q   <= dir_d;
      shamt_q <= shamt_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign found     = found_q;
  assign direction = dir_q;
  assign shamt     = shamt_q;
endmodule

// File: tb/tb_six_bit_rotate_solver.sv
// tb_six_bit_rotate_solver: vector table, random model checks, corner sequences and exhaustive round-trip.
module tb_six_bit_rotate_solver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] xval = '0, tval = '0;
  logic       busy, done, found, direction;
  logic [2:0] shamt;
  logic       busy0, done0, found0, direction0;
  logic [2:0] shamt0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  six_bit_rotate_solver #(.CANONICAL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .xVal(xval), .targetVal(tval),
    .busy(busy), .done(done), .found(found), .direction(direction), .shamt(shamt)
  );
  six_bit_rotate_solver #(.CANONICAL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .xVal(xval), .targetVal(tval),
    .busy(busy0), .done(done0), .found(found0), .direction(direction0), .shamt(shamt0)
  );

  typedef struct {
    logic [5:0] x, t;
    int f, d, s, d0, s0, lat;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // smallest left-rotation count taking x to t, or -1
  function automatic int find_k(input logic [5:0] x, input logic [5:0] t);
    for (int k = 0; k < 6; k++)
      if ((((int'(x) << k) | (int'(x) >> (6 - k))) & 63) == int'(t)) return k;
    return -1;
  endfunction

  function automatic logic [5:0] rot(input logic [5:0] v, input logic dir, input int amt);
    logic [5:0] r = v;
    for (int i = 0; i < amt; i++) r = dir ? {r[4:0], r[5]} : {r[0], r[5:1]};
    return r;
  endfunction

  // called at a negedge with both DUTs idle; returns at a negedge one cycle after done
  task automatic run(input logic [5:0] x, input logic [5:0] t, output int lat, output int busy_ok);
    start = 1'b1; xval = x; tval = t;
    @(negedge clk);
    start = 1'b0; xval = 6'($urandom); tval = 6'($urandom);
    lat = 1; busy_ok = 1;
    while (!done && lat < 20) begin
      if (!busy || !busy0 || done0) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    if (!busy || !done0) busy_ok = 0;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag, input logic [5:0] x, input logic [5:0] t);
    int lat, bok, k;
    k = find_k(x, t);
    run(x, t, lat, bok);
    check({tag, " latency"}, lat, k < 0 ? 7 : k + 2);
    check({tag, " busy"}, bok, 1);
    check({tag, " found"}, found, k >= 0);
    check({tag, " dir"}, direction, !(k > 3));
    check({tag, " shamt"}, shamt, k < 0 ? 0 : k > 3 ? 6 - k : k);
    check({tag, " found0"}, found0, k >= 0);
    check({tag, " dir0"}, direction0, 1);
    check({tag, " shamt0"}, shamt0, k < 0 ? 0 : k);
  endtask

  initial begin
    int lat, bok, ndone, first, second;
    logic [5:0] x, t;
    vecs[0] = '{6'b000001, 6'b000100, 1, 1, 2, 1, 2, 4};
    vecs[1] = '{6'b000001, 6'b010000, 1, 0, 2, 1, 4, 6};
    vecs[2] = '{6'b101010, 6'b010101, 1, 1, 1, 1, 1, 3};
    vecs[3] = '{6'b111111, 6'b111111, 1, 1, 0, 1, 0, 2};
    vecs[4] = '{6'b000011, 6'b000101, 0, 1, 0, 1, 0, 7};
    vecs[5] = '{6'b000000, 6'b000000, 1, 1, 0, 1, 0, 2};
    vecs[6] = '{6'b000001, 6'b100000, 1, 0, 1, 1, 5, 7};
    vecs[7] = '{6'b000001, 6'b001000, 1, 1, 3, 1, 3, 5};
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset found", found, 0);
    check("reset dir", direction, 0);
    check("reset shamt", shamt, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);

    foreach (vecs[i]) begin
      run(vecs[i].x, vecs[i].t, lat, bok);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d busy", i), bok, 1);
      check($sformatf("vec%0d found", i), found, vecs[i].f);
      check($sformatf("vec%0d dir", i), direction, vecs[i].d);
      check($sformatf("vec%0d shamt", i), shamt, vecs[i].s);
      check($sformatf("vec%0d found0", i), found0, vecs[i].f);
      check($sformatf("vec%0d dir0", i), direction0, vecs[i].d0);
      check($sformatf("vec%0d shamt0", i), shamt0, vecs[i].s0);
      check($sformatf("vec%0d idle done", i), done, 0);
    end

    // results hold through idle
    repeat (4) @(negedge clk);
    check("hold shamt", shamt, 3);
    check("hold found", found, 1);

    // start held high: accepted at cycles 0,3,6,9 -> done at 2,5,8,11
    ndone = 0; first = -1; second = -1;
    start = 1'b1; xval = 6'b111111; tval = 6'b111111;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i == 10) start = 1'b0;
    end
    check("held start dones", ndone, 4);
    check("held start first", first, 2);
    check("held start second", second, 5);

    // reset mid-search discards the search
    run(6'b000001, 6'b000100, lat, bok);
    start = 1'b1; xval = 6'b000011; tval = 6'b000101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset found", found, 0);
    check("midreset dir", direction, 0);
    check("midreset shamt", shamt, 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("midreset no done", ndone, 0);
    check_model("after reset", 6'b000001, 6'b010000);

    for (int i = 0; i < 150; i++) begin
      x = 6'($urandom);
      t = $urandom_range(0, 1) ? rot(x, 1'b1, $urandom_range(0, 5)) : 6'($urandom);
      check_model($sformatf("rand%0d", i), x, t);
    end

    for (int xi = 0; xi < 64; xi++)
      for (int a = 0; a < 8; a++)
        for (int d = 0; d < 2; d++) begin
          x = 6'(xi);
          t = rot(x, d[0], a);
          run(x, t, lat, bok);
          check($sformatf("rt %0d/%0d/%0d found", xi, a, d), found, 1);
          check($sformatf("rt %0d/%0d/%0d value", xi, a, d), rot(x, direction, shamt), t);
          check($sformatf("rt %0d/%0d/%0d value0", xi, a, d), rot(x, direction0, shamt0), t);
        end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
